// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants and the operand loader state encoding.
package dlfloat_pkg;

  localparam int unsigned DLF_W      = 16;
  localparam int unsigned DLF_EXP_W  = 6;
  localparam int unsigned DLF_MANT_W = 9;
  localparam int unsigned DLF_BIAS   = 31;

  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    A_LO = 3'd0,
    A_HI = 3'd1,
    B_LO = 3'd2,
    B_HI = 3'd3,
    HOLD = 3'd4
  } ld_state_e;

endpackage

// File: rtl/dlfloat_vec_counter.sv
// Pair position counter within a dot-product vector: wraps at VEC_LEN,
// cleared by reset or flush, decodes first/last pair.
module dlfloat_vec_counter #(
  parameter int unsigned VEC_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic advance,
  output logic first,
  output logic last
);

  localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  logic [CNT_W-1:0] pair_cnt;

  // Flush takes priority over a handoff so a dropped pair never counts.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pair_cnt <= '0;
    end else if (advance) begin
      pair_cnt <= (pair_cnt == LAST_CNT) ? '0 : pair_cnt + CNT_W'(1);
    end
  end

  assign first = (pair_cnt == '0);
  assign last  = (pair_cnt == LAST_CNT);

endmodule

// File: rtl/dlfloat_operand_loader.sv
// Byte-serial to DLFloat16 operand-pair loader with valid/ready handoff.
// Optional operand zero/NaN flags are built when DLFLOAT_OPCHK_EN is defined.
module dlfloat_operand_loader
  import dlfloat_pkg::*;
#(
  parameter int unsigned VEC_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             flush,
  output logic [DLF_W-1:0] op_a,
  output logic [DLF_W-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             op_first,
  output logic             op_last,
  output logic             op_zero,
  output logic             op_nan
);

  ld_state_e state;
  logic      accept;
  logic      handoff;
  logic      cnt_first;
  logic      cnt_last;

  assign byte_ready = (state != HOLD);
  assign op_valid   = (state == HOLD);
  assign accept     = byte_valid && byte_ready;
  assign handoff    = op_valid && op_ready;

  // Byte assembly FSM; flush restarts the pair but keeps the operand bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= A_LO;
      op_a  <= '0;
      op_b  <= '0;
    end else if (flush) begin
      state <= A_LO;
    end else begin
      case (state)
        A_LO: if (accept) begin op_a[7:0]  <= byte_in; state <= A_HI; end
        A_HI: if (accept) begin op_a[15:8] <= byte_in; state <= B_LO; end
        B_LO: if (accept) begin op_b[7:0]  <= byte_in; state <= B_HI; end
        B_HI: if (accept) begin op_b[15:8] <= byte_in; state <= HOLD; end
        HOLD: if (op_ready) state <= A_LO;
        default: state <= A_LO;
      endcase
    end
  end

  dlfloat_vec_counter #(
    .VEC_LEN (VEC_LEN)
  ) u_vec_counter (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .advance (handoff),
    .first   (cnt_first),
    .last    (cnt_last)
  );

  assign op_first = op_valid && cnt_first;
  assign op_last  = op_valid && cnt_last;

`ifdef DLFLOAT_OPCHK_EN
  logic             nan_q;
  logic             zero_q;
  logic             nan_n;
  logic [DLF_W-1:0] b_full;

  assign b_full = {byte_in, op_b[7:0]};
  assign nan_n  = (op_a == DLF_NAN) || (b_full == DLF_NAN);

  // Flags are captured on the final byte, from the operands as they enter HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      nan_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!flush && (state == B_HI) && accept) begin
      nan_q  <= nan_n;
      zero_q <= !nan_n && ((op_a == DLF_ZERO) || (b_full == DLF_ZERO));
    end
  end

  assign op_nan  = op_valid && nan_q;
  assign op_zero = op_valid && zero_q;
`else
  assign op_nan  = 1'b0;
  assign op_zero = 1'b0;
`endif

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Scoreboard bench for dlfloat_operand_loader (VEC_LEN=4).
// Honours DLFLOAT_OPCHK_EN for the expected flag values.
module tb_dlfloat_operand_loader;

  localparam int unsigned VEC_LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic        op_first;
  logic        op_last;
  logic        op_zero;
  logic        op_nan;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        first;
    logic        last;
    logic        zero;
    logic        nan;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   model_cnt = 0;

  always #5 clk = ~clk;

  dlfloat_operand_loader #(.VEC_LEN(VEC_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .flush      (flush),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_first   (op_first),
    .op_last    (op_last),
    .op_zero    (op_zero),
    .op_nan     (op_nan)
  );

  function automatic exp_t make_exp(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.a     = a;
    e.b     = b;
    e.first = (model_cnt == 0);
    e.last  = (model_cnt == int'(VEC_LEN) - 1);
`ifdef DLFLOAT_OPCHK_EN
    e.nan   = (a == 16'hFFFF) || (b == 16'hFFFF);
    e.zero  = !e.nan && ((a == 16'h0000) || (b == 16'h0000));
`else
    e.nan   = 1'b0;
    e.zero  = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.a = op_a; o.b = op_b; o.first = op_first; o.last = op_last;
    o.zero = op_zero; o.nan = op_nan;
    return o;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_ready: byte_ready=%b required=1 (timeout)", byte_ready);
      return;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    sb.push_back(make_exp(a, b));
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
  endtask

  // Pops one expectation, stalls hold_cycles with a stray byte offered, then hands off.
  task automatic recv_pair(input int hold_cycles, input string name);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!op_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue empty, required one entry", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (op_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout: op_valid=%b required=1", name, op_valid);
      return;
    end
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL %s_pair: got a=%h b=%h f=%b l=%b z=%b n=%b required a=%h b=%h f=%b l=%b z=%b n=%b",
               name, op_a, op_b, op_first, op_last, op_zero, op_nan,
               e.a, e.b, e.first, e.last, e.zero, e.nan);
    end
    for (int i = 0; i < hold_cycles; i++) begin
      byte_in    = 8'hAA;
      byte_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (op_valid !== 1'b1 || byte_ready !== 1'b0 || observed() !== e) begin
        errors++;
        $display("FAIL %s_stall%0d: valid=%b ready=%b a=%h b=%h required valid=1 ready=0 a=%h b=%h",
                 name, i, op_valid, byte_ready, op_a, op_b, e.a, e.b);
      end
    end
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready   = 1'b0;
    byte_valid = 1'b0;
    model_cnt  = (model_cnt == int'(VEC_LEN) - 1) ? 0 : model_cnt + 1;
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handoff: valid=%b ready=%b required valid=0 ready=1", name, op_valid, byte_ready);
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    checks++;
    if ({op_valid, byte_ready, op_a, op_b, op_zero, op_nan, op_first, op_last} !== {1'b0, 1'b1, 32'h0, 4'b0}) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b a=%h b=%h z=%b n=%b f=%b l=%b required 0 1 0000 0000 0 0 0 0",
               op_valid, byte_ready, op_a, op_b, op_zero, op_nan, op_first, op_last);
    end
  endtask

  task automatic test_basic();
    send_pair(16'h3E00, 16'h4000);
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: op_valid=%b required=1 one cycle after 4th byte", op_valid);
    end
    recv_pair(0, "basic");
  endtask

  task automatic test_backpressure();
    send_pair(16'h1234, 16'hABCD);
    recv_pair(10, "backpressure");
    send_pair(16'h5566, 16'h7788);
    recv_pair(0, "after_stall");
  endtask

  task automatic test_wrap();
    pulse_flush();
    for (int i = 0; i < 5; i++) begin
      send_pair(16'(16'h0100 + i), 16'(16'h0200 + i));
      recv_pair(i % 2, "wrap");
    end
  endtask

  task automatic test_flush();
    exp_t dropped;
    pulse_flush();
    send_pair(16'h1111, 16'h2222);
    recv_pair(0, "flush_pre");
    send_byte(8'h33);
    send_byte(8'h44);
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: byte_ready=%b required=1", byte_ready);
    end
    flush      = 1'b1;
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    byte_valid = 1'b0;
    model_cnt  = 0;
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_partial: valid=%b ready=%b required valid=0 ready=1", op_valid, byte_ready);
    end
    send_pair(16'h3E00, 16'h4000);
    recv_pair(0, "flush_next");
    send_pair(16'h6666, 16'h7777);
    @(negedge clk);
    dropped  = sb.pop_back();
    flush    = 1'b1;
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    op_ready  = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b0 || op_a !== dropped.a) begin
      errors++;
      $display("FAIL flush_hold: valid=%b a=%h required valid=0 a=%h", op_valid, op_a, dropped.a);
    end
    send_pair(16'h0A0B, 16'h0C0D);
    recv_pair(0, "flush_hold_next");
  endtask

  task automatic test_mid_reset();
    pulse_flush();
    send_byte(8'hF1);
    send_byte(8'hF2);
    send_byte(8'hF3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    checks++;
    if (op_valid !== 1'b0 || byte_ready !== 1'b1 || op_a !== 16'h0 || op_b !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ready=%b a=%h b=%h required 0 1 0000 0000",
               op_valid, byte_ready, op_a, op_b);
    end
    send_pair(16'h0201, 16'h0403);
    recv_pair(0, "mid_reset_pair");
  endtask

  task automatic test_flags();
    send_pair(16'hFFFF, 16'h0000);
    recv_pair(1, "flag_nan");
    send_pair(16'h0000, 16'h3E00);
    recv_pair(0, "flag_zero");
    send_pair(16'h3E00, 16'hFFFF);
    recv_pair(0, "flag_nan_b");
    send_pair(16'h1234, 16'h5678);
    recv_pair(0, "flag_none");
  endtask

  initial begin
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    flush      = 1'b0;
    op_ready   = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_flush();
    test_mid_reset();
    test_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlfloat_operand_loader.md
Name: dlfloat_operand_loader

Overview:
Upstream stage of the DLFloat16 MAC. Collects a byte-serial input stream (low byte first) into operand pairs A/B and presents each pair to the MAC with a valid/ready handshake. Tracks position within a dot-product vector of VEC_LEN pairs, so the MAC knows when to clear its accumulator (first pair) and when the result is final (last pair).

Parameters:
VEC_LEN, 4, number of operand pairs per dot-product vector; legal range 1..256.
CNT_W, $clog2(VEC_LEN) (minimum 1), width of the internal pair counter; derived, never overridden.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
byte_in  in  8  serial operand byte.
byte_valid  in  1  byte_in is valid this cycle.
byte_ready  out  1  loader accepts byte_in this cycle.
flush  in  1  synchronous abort: drop the partial or held pair and restart the vector.
op_a  out  16  operand A in DLFloat16 format: sign[15], exp[14:9] with bias 31, mant[8:0].
op_b  out  16  operand B, same format.
op_valid  out  1  op_a/op_b/op_first/op_last are valid.
op_ready  in  1  MAC consumes the pair.
op_first  out  1  held pair is pair 0 of the vector.
op_last  out  1  held pair is pair VEC_LEN-1 of the vector.
op_zero  out  1  either operand equals 0x0000 (see Optional Feature).
op_nan  out  1  either operand equals 0xFFFF (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge) puts the block in this state:
  - state=A_LO, pair_cnt=0, op_a=op_b=0;
  - op_valid=0, op_zero=0, op_nan=0;
  - byte_ready=1 on the first cycle after reset.
  - Reset applied mid-operation discards everything.
- FSM states: A_LO -> A_HI -> B_LO -> B_HI -> HOLD -> A_LO.
  - A byte is accepted when byte_valid && byte_ready.
  - Each accept advances exactly one state. With no accept, the state holds.
  - A_LO writes op_a[7:0], A_HI writes op_a[15:8], B_LO writes op_b[7:0], B_HI writes op_b[15:8].
- byte_ready = (state != HOLD). It is decoded from registered state only, with no combinational path from op_ready.
- op_valid = (state == HOLD).
  - Latency: op_valid rises in the cycle after the 4th byte is accepted.
  - In HOLD, op_a, op_b, op_first, op_last and the flags stay stable until op_ready=1.
- Handoff occurs when state==HOLD and op_ready=1. On that edge:
  - next state = A_LO;
  - pair_cnt = (pair_cnt == VEC_LEN-1) ? 0 : pair_cnt+1.
  - No byte is accepted in the handoff cycle. Peak throughput is one pair per 5 cycles.
- op_ready while not in HOLD is ignored.
- op_first = (pair_cnt == 0) and op_last = (pair_cnt == VEC_LEN-1), both qualified by op_valid. With VEC_LEN=1, both are high for every pair.
- Wrap-around: after the last pair is handed off, the next pair is automatically first.
- flush=1 forces state=A_LO and pair_cnt=0. op_a/op_b keep their values but are not valid.
  - flush has priority over a simultaneous byte accept (the byte is dropped) and over a simultaneous handoff (the pair is dropped, the counter is not incremented).
  - byte_ready stays 1 during the flush cycle when the state is not HOLD.
- Operand values pass through unmodified; the loader does no normalisation.

Optional Feature:
Macro DLFLOAT_OPCHK_EN.
- Defined:
  - op_zero and op_nan are registered in the cycle that enters HOLD, computed from the assembled operands.
  - op_nan has priority: if either operand is 0xFFFF, op_zero=0.
  - Both flags are qualified by op_valid.
- Undefined: op_zero and op_nan are tied to 0 and no compare logic is built. The ports remain.

Decomposition:
- Package dlfloat_pkg:
  - DLF_W=16, DLF_EXP_W=6, DLF_MANT_W=9, DLF_BIAS=31;
  - DLF_NAN=16'hFFFF, DLF_ZERO=16'h0000;
  - loader FSM state enum (A_LO, A_HI, B_LO, B_HI, HOLD).
- Natural sub-module: dlfloat_vec_counter, holding pair_cnt, wrap, first/last decode and flush clear. Everything else stays in the top.

Test Plan:
- Basic pair: bytes 00,3E,00,40 with byte_valid held high and op_ready=1 → op_a=0x3E00, op_b=0x4000; op_valid is high 1 cycle after the 4th byte; op_first=1, op_last=0.
- Backpressure: op_ready=0 for 10 cycles in HOLD → op_valid stays 1, outputs stay stable, byte_ready=0, an extra byte_valid is not consumed; op_ready=1 → handoff and byte_ready=1 in the next cycle.
- Vector wrap, VEC_LEN=4: 5 pairs → op_first on pairs 0 and 4, op_last on pair 3 only.
- Flush: flush after the 2nd byte of pair 1 → pair is discarded; the next full pair has op_first=1. Flush with op_ready in HOLD → no handoff, pair_cnt=0.
- Mid-reset: rst during B_HI → op_valid=0, byte_ready=1 next cycle; the following 4 bytes 01,02,03,04 → op_a=0x0201, op_b=0x0403, op_first=1.
- DLFLOAT_OPCHK_EN defined: pair A=0xFFFF, B=0x0000 → op_nan=1, op_zero=0. Pair A=0x0000, B=0x3E00 → op_zero=1. Undefined: both flags are always 0.
